// File: rtl/decode_stage_if.sv
// Bus bundle between the IF/ID register, register file, writeback, EX and the decode stage.
// Optional DECODE_ILLEGAL_TRAP_EN adds the ex_illegal flag to the ID/EX payload.
interface decode_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic             id_valid;
   logic [31:0]      id_instr;
   logic [XLEN-1:0]  id_pc;
   logic [4:0]       rf_rs1;
   logic [4:0]       rf_rs2;
   logic [XLEN-1:0]  rf_rs1_data;
   logic [XLEN-1:0]  rf_rs2_data;
   logic             wb_we;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             ex_flush;
   logic             ex_hold;
   logic             stall_if;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_rs1_val;
   logic [XLEN-1:0]  ex_rs2_val;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [6:0]       ex_opcode;
   logic [2:0]       ex_funct3;
   logic             ex_funct7b5;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic             ex_mem_write;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic             ex_illegal;
`endif

   modport master (
      output id_valid, id_instr, id_pc, rf_rs1_data, rf_rs2_data,
             wb_we, wb_rd, wb_data, ex_flush, ex_hold,
      input  rf_rs1, rf_rs2, stall_if, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val,
             ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
`ifdef DECODE_ILLEGAL_TRAP_EN
             ex_illegal,
`endif
             ex_reg_write, ex_mem_read, ex_mem_write
   );

   modport slave (
      input  id_valid, id_instr, id_pc, rf_rs1_data, rf_rs2_data,
             wb_we, wb_rd, wb_data, ex_flush, ex_hold,
      output rf_rs1, rf_rs2, stall_if, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val,
             ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
`ifdef DECODE_ILLEGAL_TRAP_EN
             ex_illegal,
`endif
             ex_reg_write, ex_mem_read, ex_mem_write
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: operand read/bypass, immediate and control decode, ID/EX register, load-use stall.
// Optional DECODE_ILLEGAL_TRAP_EN flags non-base opcodes on ex_illegal instead of passing them as NOPs.
module decode_stage #(
   parameter int unsigned XLEN         = 32,
   parameter bit          NOP_ON_RESET = 1'b1
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic            is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
   logic            uses_rs1, uses_rs2;
   logic            dec_reg_write, dec_mem_read, dec_mem_write;
   logic [31:0]     imm32;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            load_use;

   logic            valid_q;
   logic [XLEN-1:0] pc_q, rs1_val_q, rs2_val_q, imm_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [6:0]      opcode_q;
   logic [2:0]      funct3_q;
   logic            funct7b5_q, reg_write_q, mem_read_q, mem_write_q;

   assign instr  = bus.id_instr;
   assign opcode = instr[6:0];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];

   assign is_r      = (opcode == OP_R);
   assign is_imm    = (opcode == OP_IMM);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);

   assign uses_rs1 = is_r | is_imm | is_load | is_store | is_branch | is_jalr;
   assign uses_rs2 = is_r | is_store | is_branch;

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic illegal_q;
   logic dec_illegal;
   logic known_op;

   assign known_op    = is_r | is_imm | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;
   assign dec_illegal = bus.id_valid && (!known_op || (instr[1:0] != 2'b11));
`else
   logic dec_illegal;

   assign dec_illegal = 1'b0;
`endif

   // Illegal encodings keep ex_valid but carry no side effects.
   assign dec_reg_write = (is_r | is_imm | is_load | is_jal | is_jalr | is_lui | is_auipc)
                          && (rd != 5'd0) && !dec_illegal;
   assign dec_mem_read  = is_load && !dec_illegal;
   assign dec_mem_write = is_store && !dec_illegal;

   always_comb begin
      imm32 = 32'd0;
      unique case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'd0};
         OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:                  imm32 = 32'd0;
      endcase
   end

   // x0 reads as zero; a same-cycle writeback beats the stale register-file value.
   function automatic logic [XLEN-1:0] sel_operand(input logic [4:0] idx, input logic [XLEN-1:0] rf_data,
                                                   input logic we, input logic [4:0] wrd,
                                                   input logic [XLEN-1:0] wdata);
      if (idx == 5'd0)              return '0;
      else if (we && (wrd == idx))  return wdata;
      else                          return rf_data;
   endfunction

   assign rs1_val = sel_operand(rs1, bus.rf_rs1_data, bus.wb_we, bus.wb_rd, bus.wb_data);
   assign rs2_val = sel_operand(rs2, bus.rf_rs2_data, bus.wb_we, bus.wb_rd, bus.wb_data);

   assign load_use = valid_q && mem_read_q && (rd_q != 5'd0) && bus.id_valid &&
                     ((uses_rs1 && (rd_q == rs1)) || (uses_rs2 && (rd_q == rs2)));

   assign bus.stall_if = !bus.ex_flush && (bus.ex_hold || load_use);
   assign bus.rf_rs1   = rs1;
   assign bus.rf_rs2   = rs2;

   // ID/EX register: reset > flush > hold > load-use bubble > capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_q   <= 1'b0;
`endif
         if (NOP_ON_RESET) begin
            pc_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            opcode_q   <= 7'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
         end
      end else if (bus.ex_flush || (!bus.ex_hold && load_use)) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_q   <= 1'b0;
`endif
      end else if (!bus.ex_hold) begin
         valid_q     <= bus.id_valid;
         reg_write_q <= bus.id_valid && dec_reg_write;
         mem_read_q  <= bus.id_valid && dec_mem_read;
         mem_write_q <= bus.id_valid && dec_mem_write;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_q   <= dec_illegal;
`endif
         pc_q        <= bus.id_pc;
         rs1_val_q   <= rs1_val;
         rs2_val_q   <= rs2_val;
         imm_q       <= XLEN'($signed(imm32));
         rs1_q       <= rs1;
         rs2_q       <= rs2;
         rd_q        <= rd;
         opcode_q    <= opcode;
         funct3_q    <= instr[14:12];
         funct7b5_q  <= instr[30];
      end
   end

   assign bus.ex_valid     = valid_q;
   assign bus.ex_pc        = pc_q;
   assign bus.ex_rs1_val   = rs1_val_q;
   assign bus.ex_rs2_val   = rs2_val_q;
   assign bus.ex_imm       = imm_q;
   assign bus.ex_rs1       = rs1_q;
   assign bus.ex_rs2       = rs2_q;
   assign bus.ex_rd        = rd_q;
   assign bus.ex_opcode    = opcode_q;
   assign bus.ex_funct3    = funct3_q;
   assign bus.ex_funct7b5  = funct7b5_q;
   assign bus.ex_reg_write = reg_write_q;
   assign bus.ex_mem_read  = mem_read_q;
   assign bus.ex_mem_write = mem_write_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign bus.ex_illegal   = illegal_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued at drive time and checked after the edge.
module tb_decode_stage;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [31:0] I_ADDI_M1 = 32'hFFF00293;  // addi x5,x0,-1
   localparam logic [31:0] I_ADDI_X7 = 32'h00138413;  // addi x8,x7,1
   localparam logic [31:0] I_LW      = 32'h0000A183;  // lw x3,0(x1)
   localparam logic [31:0] I_ADD     = 32'h00218233;  // add x4,x3,x2
   localparam logic [31:0] I_SW      = 32'h0020A423;  // sw x2,8(x1)
   localparam logic [31:0] I_BEQ     = 32'hFE000CE3;  // beq x0,x0,-8
   localparam logic [31:0] I_BAD     = 32'h0000007F;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1_val, rs2_val, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        f7b5, rw, mr, mw, ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [31:0] rf [32];
   logic [31:0] pc;
   exp_t mdl;
   exp_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) bus ();
   decode_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always_comb begin
      bus.rf_rs1_data = rf[bus.rf_rs1];
      bus.rf_rs2_data = rf[bus.rf_rs2];
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_operand(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
      return rf[idx];
   endfunction

   function automatic logic ref_uses1(input logic [6:0] op);
      return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
   endfunction

   function automatic logic ref_uses2(input logic [6:0] op);
      return op inside {OP_R, OP_STORE, OP_BRANCH};
   endfunction

   function automatic exp_t ref_decode(input logic v, input logic [31:0] ins, input logic [31:0] p);
      exp_t e;
      logic [6:0] op;
      logic known;
      e = '0;
      op = ins[6:0];
      e.valid = v;  e.pc = p;  e.opcode = op;
      e.rs1 = ins[19:15];  e.rs2 = ins[24:20];  e.rd = ins[11:7];
      e.funct3 = ins[14:12];  e.f7b5 = ins[30];
      e.rs1_val = ref_operand(ins[19:15]);
      e.rs2_val = ref_operand(ins[24:20]);
      case (op)
         OP_IMM, OP_LOAD, OP_JALR: e.imm = 32'($signed(ins) >>> 20);
         OP_STORE:  e.imm = (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | {27'd0, ins[11:7]};
         OP_BRANCH: e.imm = (32'($signed(ins) >>> 19) & 32'hFFFF_F000) |
                            {20'd0, ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC: e.imm = ins & 32'hFFFF_F000;
         OP_JAL:    e.imm = (32'($signed(ins) >>> 11) & 32'hFFF0_0000) |
                            {12'd0, ins[19:12], ins[20], ins[30:21], 1'b0};
         default:   e.imm = 32'd0;
      endcase
      known = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      e.rw = v && (op inside {OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}) && (e.rd != 5'd0);
      e.mr = v && (op == OP_LOAD);
      e.mw = v && (op == OP_STORE);
      e.ill = v && (!known || ins[1:0] != 2'b11);
      return e;
   endfunction

   task automatic compare_all(input string tag, input exp_t e);
      check_eq({tag, ".valid"},   32'(bus.ex_valid), 32'(e.valid));
      check_eq({tag, ".rw"},      32'(bus.ex_reg_write), 32'(e.rw));
      check_eq({tag, ".mr"},      32'(bus.ex_mem_read), 32'(e.mr));
      check_eq({tag, ".mw"},      32'(bus.ex_mem_write), 32'(e.mw));
      check_eq({tag, ".pc"},      bus.ex_pc, e.pc);
      check_eq({tag, ".rs1_val"}, bus.ex_rs1_val, e.rs1_val);
      check_eq({tag, ".rs2_val"}, bus.ex_rs2_val, e.rs2_val);
      check_eq({tag, ".imm"},     bus.ex_imm, e.imm);
      check_eq({tag, ".rs1"},     32'(bus.ex_rs1), 32'(e.rs1));
      check_eq({tag, ".rs2"},     32'(bus.ex_rs2), 32'(e.rs2));
      check_eq({tag, ".rd"},      32'(bus.ex_rd), 32'(e.rd));
      check_eq({tag, ".opcode"},  32'(bus.ex_opcode), 32'(e.opcode));
      check_eq({tag, ".funct3"},  32'(bus.ex_funct3), 32'(e.funct3));
      check_eq({tag, ".f7b5"},    32'(bus.ex_funct7b5), 32'(e.f7b5));
`ifdef DECODE_ILLEGAL_TRAP_EN
      check_eq({tag, ".illegal"}, 32'(bus.ex_illegal), 32'(e.ill));
`endif
   endtask

   // One clock: drive ID inputs, check combinational outputs, queue the expected ID/EX state, check it after the edge.
   task automatic cycle(input string tag, input logic r, input logic v, input logic [31:0] ins,
                        input logic f, input logic h);
      exp_t nxt;
      exp_t got;
      logic lu;
      reset = r;  bus.id_valid = v;  bus.id_instr = ins;  bus.id_pc = pc;
      bus.ex_flush = f;  bus.ex_hold = h;
      @(negedge clk);
      check_eq({tag, ".rf_rs1"}, 32'(bus.rf_rs1), 32'(ins[19:15]));
      check_eq({tag, ".rf_rs2"}, 32'(bus.rf_rs2), 32'(ins[24:20]));
      lu = mdl.valid && mdl.mr && (mdl.rd != 5'd0) && v &&
           ((ref_uses1(ins[6:0]) && mdl.rd == ins[19:15]) || (ref_uses2(ins[6:0]) && mdl.rd == ins[24:20]));
      check_eq({tag, ".stall_if"}, 32'(bus.stall_if), 32'(!f && (h || lu)));
      if (r) nxt = '0;
      else if (f || (!h && lu)) begin
         nxt = mdl;
         nxt.valid = 1'b0;  nxt.rw = 1'b0;  nxt.mr = 1'b0;  nxt.mw = 1'b0;  nxt.ill = 1'b0;
      end else if (h) nxt = mdl;
      else nxt = ref_decode(v, ins, pc);
      exp_q.push_back(nxt);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      compare_all(tag, got);
      mdl = got;
      pc = pc + 32'd4;
   endtask

   initial begin
      logic [6:0] ops [9];
      logic [31:0] ins;
      ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | (32'(i) * 32'h0001_0101);
      rf[0] = 32'h0000_DEAD;
      pc = 32'h0000_0100;
      reset = 1'b1;
      bus.id_valid = 1'b0;  bus.id_instr = 32'd0;  bus.id_pc = 32'd0;
      bus.wb_we = 1'b0;  bus.wb_rd = 5'd0;  bus.wb_data = 32'd0;
      bus.ex_flush = 1'b0;  bus.ex_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mdl = '0;
      compare_all("reset", mdl);
      check_eq("reset.stall_if", 32'(bus.stall_if), 32'd0);

      cycle("addi", 1'b0, 1'b1, I_ADDI_M1, 1'b0, 1'b0);
      check_eq("addi.imm_const", bus.ex_imm, 32'hFFFF_FFFF);
      check_eq("addi.rs1_val_x0", bus.ex_rs1_val, 32'd0);
      check_eq("addi.rd_const", 32'(bus.ex_rd), 32'd5);

      bus.wb_we = 1'b1;  bus.wb_rd = 5'd7;  bus.wb_data = 32'h0000_1234;
      cycle("bypass", 1'b0, 1'b1, I_ADDI_X7, 1'b0, 1'b0);
      check_eq("bypass.const", bus.ex_rs1_val, 32'h0000_1234);
      bus.wb_we = 1'b0;

      cycle("lu.lw", 1'b0, 1'b1, I_LW, 1'b0, 1'b0);
      cycle("lu.bubble", 1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
      check_eq("lu.bubble_valid", 32'(bus.ex_valid), 32'd0);
      cycle("lu.add", 1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
      check_eq("lu.add_rs1", 32'(bus.ex_rs1), 32'd3);
      check_eq("lu.add_valid", 32'(bus.ex_valid), 32'd1);

      cycle("fl.lw", 1'b0, 1'b1, I_LW, 1'b0, 1'b0);
      cycle("fl.flush", 1'b0, 1'b1, I_ADD, 1'b1, 1'b0);
      check_eq("fl.valid", 32'(bus.ex_valid), 32'd0);

      cycle("hd.sw", 1'b0, 1'b1, I_SW, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cycle("hd.hold", 1'b0, 1'b1, I_ADDI_M1, 1'b0, 1'b1);
      check_eq("hd.sw_kept", 32'(bus.ex_mem_write), 32'd1);
      check_eq("hd.imm_kept", bus.ex_imm, 32'd8);
      cycle("hd.release", 1'b0, 1'b1, I_ADDI_M1, 1'b0, 1'b0);

      cycle("hl.lw", 1'b0, 1'b1, I_LW, 1'b0, 1'b0);
      cycle("hl.hold", 1'b0, 1'b1, I_ADD, 1'b0, 1'b1);
      cycle("hl.bubble", 1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
      cycle("hl.add", 1'b0, 1'b1, I_ADD, 1'b0, 1'b0);

      cycle("rs.lw", 1'b0, 1'b1, I_LW, 1'b0, 1'b0);
      cycle("rs.reset", 1'b1, 1'b1, I_ADD, 1'b0, 1'b0);
      cycle("rs.after", 1'b0, 1'b1, I_ADD, 1'b0, 1'b0);

      cycle("beq", 1'b0, 1'b1, I_BEQ, 1'b0, 1'b0);
      check_eq("beq.imm_const", bus.ex_imm, 32'hFFFF_FFF8);
      check_eq("beq.rw_const", 32'(bus.ex_reg_write), 32'd0);

      cycle("bad", 1'b0, 1'b1, I_BAD, 1'b0, 1'b0);
      check_eq("bad.valid", 32'(bus.ex_valid), 32'd1);
`ifdef DECODE_ILLEGAL_TRAP_EN
      check_eq("bad.illegal", 32'(bus.ex_illegal), 32'd1);
`endif

      for (int k = 0; k < 80; k++) begin
         ins = $urandom;
         ins[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
         ins[11:7]  = 5'($urandom_range(0, 5));
         ins[19:15] = 5'($urandom_range(0, 5));
         ins[24:20] = 5'($urandom_range(0, 5));
         bus.wb_we   = 1'($urandom_range(0, 1));
         bus.wb_rd   = 5'($urandom_range(0, 5));
         bus.wb_data = $urandom;
         cycle("rnd", 1'b0, ($urandom_range(0, 9) != 0), ins,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline. Sits between the IF/ID register and EX.
- Drives the register-file read addresses and forces x0 reads to zero. Bypasses a same-cycle writeback because the register file has no write-first path.
- Generates the immediate and control signals, and owns the ID/EX pipeline register.
- Detects load-use hazards and handles EX flush and stall requests.

Parameters:
- XLEN, 32, datapath and PC width.
- NOP_ON_RESET, 1, when 1, ID/EX payload fields are cleared on reset as well as ex_valid.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a live instruction.
- id_instr  in  32  instruction from IF/ID.
- id_pc  in  XLEN  PC of id_instr.
- rf_rs1  out  5  register-file read address 1, equal to id_instr[19:15].
- rf_rs2  out  5  register-file read address 2, equal to id_instr[24:20].
- rf_rs1_data  in  XLEN  combinational read data 1.
- rf_rs2_data  in  XLEN  combinational read data 2.
- wb_we  in  1  writeback write enable, same signals that feed the register file.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_flush  in  1  redirect from EX (taken branch or jump).
- ex_hold  in  1  EX/MEM cannot accept a new instruction this cycle.
- stall_if  out  1  hold PC and IF/ID.
- ex_valid  out  1  ID/EX holds a live instruction.
- ex_pc  out  XLEN  PC of the instruction in ID/EX.
- ex_rs1_val  out  XLEN  operand 1.
- ex_rs2_val  out  XLEN  operand 2.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1  out  5  source index 1, for EX forwarding.
- ex_rs2  out  5  source index 2, for EX forwarding.
- ex_rd  out  5  destination index.
- ex_opcode  out  7  opcode field.
- ex_funct3  out  3  funct3 field.
- ex_funct7b5  out  1  instr[30].
- ex_reg_write  out  1  instruction writes rd, and rd is not 0.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.

Behaviour:
- Reset (synchronous, active-high): ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0. If NOP_ON_RESET=1, all other ex_* outputs are 0. stall_if is combinational and reads 0 while ex_valid=0.
- Register reads are combinational. Operand value selection, in order:
  - index 0 -> 0;
  - wb_we && wb_rd==index -> wb_data;
  - otherwise -> rf data.
- Immediate generation by opcode:
  - I-type (0010011, 0000011, 1100111): instr[31:20], sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]}, sign-extended.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - R-type and unknown opcodes: 0.
- Source usage:
  - uses_rs1: R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: R, STORE, BRANCH.
- Destination write: reg_write applies to R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC, and only when rd is not 0.
- Load-use hazard: asserted when ex_valid && ex_mem_read && ex_rd is not 0 && id_valid, and either (uses_rs1 && ex_rd==rs1) or (uses_rs2 && ex_rd==rs2).
- ID/EX update at each posedge, highest priority first:
  1. reset.
  2. ex_flush: ex_valid<=0 and control signals<=0. IF/ID is squashed upstream.
  3. ex_hold: all ID/EX contents held.
  4. load-use: bubble inserted; ex_valid<=0 and control signals<=0.
  5. Otherwise: decoded fields are captured and ex_valid<=id_valid. Control signals are gated by id_valid.
- stall_if = !ex_flush && (ex_hold || load_use). It is combinational, with zero-cycle latency.
- Latency: one cycle from IF/ID to ID/EX.
- A stall lasts exactly one cycle per load-use hazard. After the bubble, the hazard clears and the EX forwarding unit supplies the load result.
- ex_flush and load_use together: the flush wins and stall_if=0.
- ex_hold and load_use together: the register holds and stall_if=1. The hazard is re-evaluated next cycle.
- Reset asserted mid-stall: ID/EX is cleared, so stall_if=0 in the following cycle.

Optional Feature:
- DECODE_ILLEGAL_TRAP_EN defined:
  - adds output ex_illegal (1 bit, reset 0);
  - set when id_valid and the opcode is not one of the nine RV32I base opcodes above, or instr[1:0] is not 11;
  - an illegal instruction gets ex_valid=1 with all control signals 0;
  - ex_illegal follows the same hold, flush and bubble rules as the other ID/EX fields.
- Not defined: no port. Illegal encodings pass through as a valid NOP, with reg_write=0 and mem_read/mem_write=0.

Test Plan:
- Reset, then id_valid=1 with addi x5,x0,-1 (0xFFF00293) -> next cycle ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFF, ex_rs1_val=0, ex_reg_write=1.
- rf_rs1_data=0xDEAD with rs1=x0 -> ex_rs1_val=0. With rs1=x7, wb_we=1, wb_rd=7, wb_data=0x1234 -> ex_rs1_val=0x1234.
- lw x3,0(x1) in ID/EX with add x4,x3,x2 in ID -> stall_if=1 for one cycle and ex_valid=0 (bubble). The add enters next cycle with ex_rs1=3.
- Same load-use pair plus ex_flush=1 -> stall_if=0 and ex_valid=0 next cycle.
- ex_hold=1 for 3 cycles with sw in ID/EX -> ex_* stable, stall_if=1 throughout. Release -> the next instruction is captured.
- beq imm=-8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8, ex_reg_write=0. With DECODE_ILLEGAL_TRAP_EN, instr 0x0000007F -> ex_illegal=1, ex_valid=1.
